// File: rtl/cpu_memory_arbiter.sv
// Shares one single-ported memory among NUM_CORES cores: one grant per cycle (round-robin or fixed
// priority), combinational memory port from the winner, pipelined read-return tracking.
module cpu_memory_arbiter #(
  parameter int NUM_CORES    = 2,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             core_request,
  input  logic [NUM_CORES-1:0]             core_write_enable,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_address,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_write_data,
  output logic [NUM_CORES-1:0]             core_grant,
  output logic [NUM_CORES-1:0]             core_read_valid,
  output logic [DATA_WIDTH-1:0]            core_read_data,
  input  logic [DATA_WIDTH-1:0]            memory_read_data,
  output logic                             memory_write_enable,
  output logic [ADDR_WIDTH-1:0]            memory_address,
  output logic [DATA_WIDTH-1:0]            memory_write_data
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [IDX_W-1:0] ptr, ptr_nxt, gnt_idx, cand;
  logic             gnt_any, rd_issue;

  logic [READ_LATENCY:1]            vld_pipe;
  logic [READ_LATENCY:1][IDX_W-1:0] idx_pipe;

  // Scan in reverse so the last hit is the candidate nearest the search start.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!reset) begin
      if (ARB_MODE == 1) begin
        for (int i = NUM_CORES-1; i >= 0; i--) begin
          cand = IDX_W'(i);
          if (core_request[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
        end
      end else begin
        for (int off = NUM_CORES-1; off >= 0; off--) begin
          cand = IDX_W'((int'(ptr) + off) % NUM_CORES);
          if (core_request[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (gnt_any)
      ptr_nxt = (gnt_idx == IDX_W'(NUM_CORES-1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_nxt;
  end

  always_comb begin
    core_grant          = '0;
    memory_write_enable = 1'b0;
    memory_address      = '0;
    memory_write_data   = '0;
    rd_issue            = 1'b0;
    if (gnt_any) begin
      core_grant[gnt_idx] = 1'b1;
      memory_write_enable = core_write_enable[gnt_idx];
      memory_address      = core_address[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      memory_write_data   = core_write_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      rd_issue            = ~core_write_enable[gnt_idx];
    end
  end

  // Stage READ_LATENCY lines up with memory_read_data for the read granted that many cycles ago.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      idx_pipe[1] <= gnt_idx;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  always_comb begin
    core_read_valid = '0;
    core_read_data  = '0;
    if (!reset && vld_pipe[READ_LATENCY]) begin
      core_read_valid[idx_pipe[READ_LATENCY]] = 1'b1;
      core_read_data                          = memory_read_data;
    end
  end
endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// Directed bench: four arbiter configurations (RR/2 cores, fixed priority, latency 3, RR/4 cores),
// with a read-return scoreboard on the round-robin 2-core instance.
module tb_cpu_memory_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: round-robin, 2 cores, latency 1, with memory model
  logic [1:0]  a_req, a_we, a_gnt, a_rv;
  logic [31:0] a_addr, a_wd;
  logic [15:0] a_rd, a_maddr, a_mwd;
  logic [15:0] a_mrd = '0;
  logic        a_mwe;

  // Instances F (fixed priority) and L (latency 3) share bundle B
  logic [1:0]  b_req, b_we, f_gnt, f_rv, l_gnt, l_rv;
  logic [31:0] b_addr, b_wd;
  logic [15:0] f_rd, f_maddr, f_mwd, l_rd, l_maddr, l_mwd;
  logic        f_mwe, l_mwe;
  logic [15:0] f_mrd = 16'h1234;
  logic [15:0] l_mrd = 16'h1234;

  // Instance C: round-robin, 4 cores
  logic [3:0]  c_req, c_we, c_gnt, c_rv;
  logic [63:0] c_addr, c_wd;
  logic [15:0] c_rd, c_maddr, c_mwd;
  logic        c_mwe;
  logic [15:0] c_mrd = 16'h00C4;

  cpu_memory_arbiter #(.NUM_CORES(2), .READ_LATENCY(1), .ARB_MODE(0)) u_rr (
    .clock(clk), .reset(rst), .core_request(a_req), .core_write_enable(a_we),
    .core_address(a_addr), .core_write_data(a_wd), .core_grant(a_gnt),
    .core_read_valid(a_rv), .core_read_data(a_rd), .memory_read_data(a_mrd),
    .memory_write_enable(a_mwe), .memory_address(a_maddr), .memory_write_data(a_mwd));

  cpu_memory_arbiter #(.NUM_CORES(2), .READ_LATENCY(1), .ARB_MODE(1)) u_fp (
    .clock(clk), .reset(rst), .core_request(b_req), .core_write_enable(b_we),
    .core_address(b_addr), .core_write_data(b_wd), .core_grant(f_gnt),
    .core_read_valid(f_rv), .core_read_data(f_rd), .memory_read_data(f_mrd),
    .memory_write_enable(f_mwe), .memory_address(f_maddr), .memory_write_data(f_mwd));

  cpu_memory_arbiter #(.NUM_CORES(2), .READ_LATENCY(3), .ARB_MODE(0)) u_l3 (
    .clock(clk), .reset(rst), .core_request(b_req), .core_write_enable(b_we),
    .core_address(b_addr), .core_write_data(b_wd), .core_grant(l_gnt),
    .core_read_valid(l_rv), .core_read_data(l_rd), .memory_read_data(l_mrd),
    .memory_write_enable(l_mwe), .memory_address(l_maddr), .memory_write_data(l_mwd));

  cpu_memory_arbiter #(.NUM_CORES(4), .READ_LATENCY(1), .ARB_MODE(0)) u_c4 (
    .clock(clk), .reset(rst), .core_request(c_req), .core_write_enable(c_we),
    .core_address(c_addr), .core_write_data(c_wd), .core_grant(c_gnt),
    .core_read_valid(c_rv), .core_read_data(c_rd), .memory_read_data(c_mrd),
    .memory_write_enable(c_mwe), .memory_address(c_maddr), .memory_write_data(c_mwd));

  // Write-first memory; unwritten locations hold addr ^ 16'hA5A5.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  logic [15:0] mem [logic [15:0]];
  always @(posedge clk) begin
    if (a_mwe) mem[a_maddr] = a_mwd;
    a_mrd <= mem.exists(a_maddr) ? mem[a_maddr] : init_val(a_maddr);
  end

  typedef struct {
    int          due;
    logic [1:0]  rv;
    logic [15:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input int core, input logic [15:0] d);
    exp_t e;
    e.due  = cyc + 1;
    e.rv   = '0;
    e.rv[core] = 1'b1;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("rr_rvalid", 32'(a_rv), 32'(e.rv));
      chk("rr_rdata", 32'(a_rd), 32'(e.data));
    end else begin
      chk("rr_rvalid_idle", 32'(a_rv), 0);
      chk("rr_rdata_idle", 32'(a_rd), 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    a_req  = 2'b11; a_we = 2'b00;
    a_addr = {16'h0020, 16'h0010}; a_wd = {16'h2222, 16'h1111};
    b_req  = 2'b11; b_we = 2'b00;
    b_addr = {16'h0020, 16'h0010}; b_wd = '0;
    c_req  = 4'b1111; c_we = 4'b1111;
    c_addr = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    c_wd   = {16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0};

    // reset held 3 cycles with every request high
    repeat (3) begin
      tick(); settle();
      chk("rst_rr_grant", 32'(a_gnt), 0);
      chk("rst_rr_mwe", 32'(a_mwe), 0);
      chk("rst_rr_maddr", 32'(a_maddr), 0);
      chk("rst_rr_mwdata", 32'(a_mwd), 0);
      chk("rst_fp_grant", 32'(f_gnt), 0);
      chk("rst_c4_grant", 32'(c_gnt), 0);
      chk("rst_c4_mwe", 32'(c_mwe), 0);
      chk("rst_c4_maddr", 32'(c_maddr), 0);
    end

    // release: core0 wins everywhere
    tick(); rst = 1'b0; settle();
    chk("rel_rr_grant", 32'(a_gnt), 32'h1);
    chk("rel_rr_maddr", 32'(a_maddr), 32'h0010);
    chk("rel_rr_mwe", 32'(a_mwe), 0);
    push_rd(0, init_val(16'h0010));
    chk("rel_fp_grant", 32'(f_gnt), 32'h1);
    chk("rel_c4_grant", 32'(c_gnt), 32'h1);
    chk("rel_c4_mwe", 32'(c_mwe), 1);
    chk("rel_c4_maddr", 32'(c_maddr), 32'h0100);
    chk("rel_c4_mwdata", 32'(c_mwd), 32'hD0D0);

    // round-robin alternation with both cores reading continuously
    for (int i = 1; i < 6; i++) begin
      tick();
      b_req = 2'b00; c_req = 4'b0000; c_we = 4'b0000;
      settle();
      chk("rr_alt_grant", 32'(a_gnt), 32'(1 << (i % 2)));
      chk("rr_alt_maddr", 32'(a_maddr), (i % 2) ? 32'h0020 : 32'h0010);
      push_rd(i % 2, init_val((i % 2) ? 16'h0020 : 16'h0010));
      if (i == 1) begin
        chk("fp_rvalid", 32'(f_rv), 32'h1);
        chk("fp_rdata", 32'(f_rd), 32'h1234);
      end
    end

    // core1 writes 0xBEEF to 0x0042, core0 reads it back next cycle
    tick();
    a_req = 2'b10; a_we = 2'b10; a_addr[31:16] = 16'h0042; a_wd[31:16] = 16'hBEEF;
    settle();
    chk("wr_grant", 32'(a_gnt), 32'h2);
    chk("wr_mwe", 32'(a_mwe), 1);
    chk("wr_maddr", 32'(a_maddr), 32'h0042);
    chk("wr_mwdata", 32'(a_mwd), 32'hBEEF);
    tick();
    a_req = 2'b01; a_we = 2'b00; a_addr[15:0] = 16'h0042;
    settle();
    chk("rd_after_wr_grant", 32'(a_gnt), 32'h1);
    chk("rd_after_wr_mwe", 32'(a_mwe), 0);
    chk("rd_after_wr_maddr", 32'(a_maddr), 32'h0042);
    push_rd(0, 16'hBEEF);
    tick(); a_req = 2'b00; settle();
    chk("idle_grant", 32'(a_gnt), 0);
    chk("idle_mwe", 32'(a_mwe), 0);
    chk("idle_maddr", 32'(a_maddr), 0);
    chk("idle_mwdata", 32'(a_mwd), 0);
    // idle cycle left the pointer at core1
    tick(); a_req = 2'b11; a_addr = {16'h0020, 16'h0010}; settle();
    chk("ptr_hold_grant", 32'(a_gnt), 32'h2);
    push_rd(1, init_val(16'h0020));
    tick(); a_req = 2'b00; settle();
    tick(); settle();
    chk("rr_sb_drained", 32'(sbq.size()), 0);

    // fixed priority: core0 starves core1 until it drops
    tick(); b_req = 2'b11; settle();
    chk("fp_grant_0", 32'(f_gnt), 32'h1);
    tick(); settle();
    chk("fp_grant_1", 32'(f_gnt), 32'h1);
    chk("fp_rvalid_b2b", 32'(f_rv), 32'h1);
    tick(); settle();
    chk("fp_grant_2", 32'(f_gnt), 32'h1);
    tick(); b_req = 2'b10; settle();
    chk("fp_grant_core1", 32'(f_gnt), 32'h2);
    tick(); b_req = 2'b00; settle();
    chk("fp_grant_none", 32'(f_gnt), 0);
    repeat (4) begin tick(); settle(); end

    // latency 3: a read returns three cycles after its grant
    tick(); b_req = 2'b01; settle();
    chk("l3_grant", 32'(l_gnt), 32'h1);
    tick(); b_req = 2'b00; settle();
    chk("l3_rv_t1", 32'(l_rv), 0);
    tick(); settle();
    chk("l3_rv_t2", 32'(l_rv), 0);
    tick(); settle();
    chk("l3_rv_t3", 32'(l_rv), 32'h1);
    chk("l3_rdata_t3", 32'(l_rd), 32'h1234);
    tick(); settle();
    chk("l3_rv_t4", 32'(l_rv), 0);

    // latency 3: reset one cycle after the grant drops the read
    tick(); b_req = 2'b01; settle();
    chk("l3_rst_grant", 32'(l_gnt), 32'h1);
    tick(); b_req = 2'b00; rst = 1'b1; settle();
    chk("l3_rst_rv_in_reset", 32'(l_rv), 0);
    tick(); rst = 1'b0; settle();
    chk("l3_rst_rv_0", 32'(l_rv), 0);
    for (int i = 1; i < 5; i++) begin
      tick(); settle();
      chk("l3_rst_rv_after", 32'(l_rv), 0);
    end

    // 4 cores: drive pointer to 3, then wrap
    tick(); c_req = 4'b0100; settle();
    chk("c4_grant_core2", 32'(c_gnt), 32'h4);
    tick(); c_req = 4'b1001; settle();
    chk("c4_grant_core3", 32'(c_gnt), 32'h8);
    chk("c4_maddr_core3", 32'(c_maddr), 32'h0103);
    tick(); c_req = 4'b0001; settle();
    chk("c4_grant_wrap", 32'(c_gnt), 32'h1);
    chk("c4_maddr_core0", 32'(c_maddr), 32'h0100);
    tick(); c_req = 4'b1111; settle();
    chk("c4_grant_ptr1", 32'(c_gnt), 32'h2);
    tick(); c_req = 4'b0000; settle();
    chk("c4_grant_none", 32'(c_gnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
